// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and constants for the systolic feed sequencer
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int   N        = 4;
  localparam int   FEED_CYC = 2 * N - 1;
  localparam logic SEL_A    = 1'b0;
  localparam logic SEL_B    = 1'b1;

endpackage

// File: rtl/sys_operand_buf.sv
// rtl/sys_operand_buf.sv - A/B operand register files with skewed row/column select for feed beat t
module sys_operand_buf
  import systolic_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            Clk,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [3:0]      wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [2:0]      t,
  output logic [N*DW-1:0] left_sel,
  output logic [N*DW-1:0] up_sel
);

  logic [DW-1:0] a_q [16];
  logic [DW-1:0] b_q [16];

  // Operand storage is deliberately not reset; contents survive an aborted operation.
  always_ff @(posedge Clk) begin
    if (wr_en && (wr_sel == SEL_A)) a_q[wr_addr] <= wr_data;
    if (wr_en && (wr_sel == SEL_B)) b_q[wr_addr] <= wr_data;
  end

  // Row i is delayed i beats, column j is delayed j beats, so PE(i,j) sees matching k.
  always_comb begin
    left_sel = '0;
    up_sel   = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(t) >= i) && (int'(t) - i < N)) begin
        left_sel[i*DW +: DW] = a_q[4'(i * N + int'(t) - i)];
        up_sel[i*DW +: DW]   = b_q[4'((int'(t) - i) * N + i)];
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - 4x4 systolic array sequencer: clear, skewed feed, drain, done
// Optional completed-operation counter on perf_ops when SYSTOLIC_PERF_CNT_EN is defined.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int DW        = 32,
  parameter int N         = 4,
  parameter int DRAIN_CYC = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [3:0]      wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            arr_clr,
  output logic [N*DW-1:0] left_data,
  output logic [N*DW-1:0] up_data,
  output logic            done,
  output logic            res_valid
`ifdef SYSTOLIC_PERF_CNT_EN
  ,
  output logic [31:0]     perf_ops
`endif
);

  localparam int DCW = $clog2(DRAIN_CYC + 1);

  state_t          state_q, state_d;
  logic [2:0]      t_q, t_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;
  logic            busy_q, busy_d;
  logic            arr_clr_q, arr_clr_d;
  logic            done_q, done_d;
  logic            res_valid_q, res_valid_d;
  logic [N*DW-1:0] left_q, left_d;
  logic [N*DW-1:0] up_q, up_d;
  logic [N*DW-1:0] left_sel, up_sel;
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0]     perf_q, perf_d;
`endif

  sys_operand_buf #(.DW(DW)) u_buf (
    .Clk      (Clk),
    .wr_en    (wr_en && !busy_q),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .t        (t_d),
    .left_sel (left_sel),
    .up_sel   (up_sel)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (t_q == 3'(FEED_CYC - 1)) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DCW'(DRAIN_CYC - 1)) state_d = DONE;
        else                               dcnt_d  = dcnt_q + DCW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    busy_d      = (state_d != IDLE);
    arr_clr_d   = (state_d == CLEAR);
    done_d      = (state_d == DONE);
    res_valid_d = res_valid_q;
    if (state_d == CLEAR)     res_valid_d = 1'b0;
    else if (state_d == DONE) res_valid_d = 1'b1;
    left_d = (state_d == FEED) ? left_sel : '0;
    up_d   = (state_d == FEED) ? up_sel   : '0;
`ifdef SYSTOLIC_PERF_CNT_EN
    perf_d = perf_q + 32'(done_d);
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      dcnt_q      <= '0;
      busy_q      <= 1'b0;
      arr_clr_q   <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      left_q      <= '0;
      up_q        <= '0;
`ifdef SYSTOLIC_PERF_CNT_EN
      perf_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      dcnt_q      <= dcnt_d;
      busy_q      <= busy_d;
      arr_clr_q   <= arr_clr_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      left_q      <= left_d;
      up_q        <= up_d;
`ifdef SYSTOLIC_PERF_CNT_EN
      perf_q      <= perf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign arr_clr   = arr_clr_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign left_data = left_q;
  assign up_data   = up_q;
`ifdef SYSTOLIC_PERF_CNT_EN
  assign perf_ops  = perf_q;
`endif

endmodule
